load_register: RTL and testbench

- General-purpose edge-triggered data register with synchronous load enable and asynchronous clear.
- Serves as the storage cell of the 32-entry register file: one instance per architectural register.
- Entry x0 instantiates it with data tied to zero and load tied high, so it always reads zero.
- All other entries share the write-data bus and receive a one-hot load from the write-address decoder.

---
 rtl/load_register.sv | 28 ++
 tb/tb_load_register.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/load_register.sv
// Edge-triggered WIDTH-bit storage cell with synchronous load and asynchronous clear.
// Used as one architectural register of the 32-entry register file.
module load_register #(
  parameter int unsigned       WIDTH       = 32,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  // The declaration initialiser gives RESET_VALUE at power-up, so entries are never X
  // in a register file that ties reset low.
  logic [WIDTH-1:0] stored = RESET_VALUE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stored <= RESET_VALUE;
    end else if (load) begin
      stored <= in;
    end
  end

  assign out = stored;

endmodule

// File: tb/tb_load_register.sv
// Self-checking bench for load_register: table-driven vectors through a scoreboard queue,
// plus hand-written sequences for asynchronous reset and between-edge stability.
module tb_load_register;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t             vecs[$];
  logic [WIDTH-1:0] sb[$];

  load_register #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(32'h0000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .in   (in),
    .out  (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: out=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one vector mid-cycle, then compare against the scoreboard just after the edge.
  task automatic step(input string name, input vec_t v);
    logic [WIDTH-1:0] e;
    @(negedge clk);
    reset = v.reset;
    load  = v.load;
    in    = v.in;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, out=%h", name, out);
    end else begin
      e = sb.pop_front();
      check(name, out, e);
    end
  endtask

  task automatic run(input string name, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) step($sformatf("%s[%0d]", name, i), vecs[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, out=%h expected=finish", out);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    load  = 1'b0;
    in    = 32'h0BAD_0BAD;

    // 0-2 power-up read, 3 load, 4-7 hold, 8 preload for reset test
    vecs.push_back('{1'b0, 1'b0, 32'h0BAD_0BAD, 32'h0000_0000});
    vecs.push_back('{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{1'b0, 1'b0, 32'h1357_9BDF, 32'h0000_0000});
    vecs.push_back('{1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
    for (int i = 0; i < 4; i++) vecs.push_back('{1'b0, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D});
    // 9-10 reset held over edges with load=1
    vecs.push_back('{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000});
    // 11-12 reset release and back-to-back loads
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0001, 32'h0000_0001});
    vecs.push_back('{1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000});
    // 13 clear before x0 run, 14-23 x0 configuration
    vecs.push_back('{1'b1, 1'b0, 32'h8765_4321, 32'h0000_0000});
    for (int i = 0; i < 10; i++) vecs.push_back('{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000});

    #1;
    check("powerup_t0", out, 32'h0000_0000);
    run("powerup", 0, 2);
    run("load_hold", 3, 8);

    // Asynchronous reset asserted between edges must clear without a clock.
    @(posedge clk);
    #2;
    check("pre_async_reset", out, 32'hCAFE_F00D);
    reset = 1'b1;
    #1;
    check("async_reset", out, 32'h0000_0000);
    run("reset_held", 9, 10);

    // Asynchronous release: out must stay cleared until the next edge.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("release_no_edge", out, 32'h0000_0000);
    run("release", 11, 12);

    // Between-edge stability: in toggles mid-cycle, only the value at the edge is taken.
    for (int k = 0; k < 2; k++) begin
      logic [WIDTH-1:0] prev, first, last;
      prev  = (k == 0) ? 32'h8000_0000 : 32'h5555_5555;
      first = (k == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
      last  = (k == 0) ? 32'h5555_5555 : 32'hAAAA_AAAA;
      @(negedge clk);
      load = 1'b1;
      in   = first;
      sb.push_back(last);
      #2;
      check($sformatf("stable_a[%0d]", k), out, prev);
      in = last;
      #1;
      check($sformatf("stable_b[%0d]", k), out, prev);
      @(posedge clk);
      #1;
      check($sformatf("edge_capture[%0d]", k), out, sb.pop_front());
    end

    run("x0", 13, 23);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
